pri_enc8_3_seq: RTL

Sequenced 8-to-3 priority encoder with request latching and a valid/acknowledge handshake; the counterpart of the 3-to-8 enabled decoder. It collects one-hot or multi-hot request lines from the multi-cycle 16-bit RISC datapath and control units. It presents the index of the highest-priority pending request on a 3-bit code and holds it until the consumer acknowledges. It then retires that request and moves on to the next.

---
 rtl/pri_enc8_3_seq.sv | 58 +++++
 1 files changed

// File: rtl/pri_enc8_3_seq.sv
// pri_enc8_3_seq: sequenced 8-to-3 priority encoder with request latching and valid/ack handshake
module pri_enc8_3_seq (
   input  logic CLK,
   input  logic RST_N,
   input  logic R0,
   input  logic R1,
   input  logic R2,
   input  logic R3,
   input  logic R4,
   input  logic R5,
   input  logic R6,
   input  logic R7,
   input  logic EN,
   input  logic ACK,
   output logic Y0,
   output logic Y1,
   output logic Y2,
   output logic VALID,
   output logic PEND
);
   typedef enum logic {IDLE, GRANT} state_t;
   state_t state, state_nxt;
   logic [7:0] r, p, p_nxt, v, clr;
   logic [2:0] y, y_nxt, top;
   logic pend;
   logic start;
   assign r = {R7, R6, R5, R4, R3, R2, R1, R0};
   assign v = p | (EN ? r : 8'h00);
   assign start = (state == IDLE) && EN && (|v);
   always_comb begin
      top = 3'd0;
      for (int i = 0; i < 8; i++) top = v[i] ? i[2:0] : top;
   end
   always_ff @(posedge CLK or negedge RST_N)
      if (!RST_N) state <= IDLE;
      else state <= state_nxt;
   always_comb
      state_nxt = (state == IDLE) ? (start ? GRANT : IDLE) : (ACK ? IDLE : GRANT);
   // clear beats a same-cycle set of the granted bit
   always_comb begin
      clr = (state == GRANT && ACK) ? (8'h01 << y) : 8'h00;
      p_nxt = v & ~clr;
      y_nxt = start ? top : y;
   end
   always_ff @(posedge CLK or negedge RST_N)
      if (!RST_N) begin
         p <= 8'h00;
         y <= 3'd0;
         pend <= 1'b0;
      end else begin
         p <= p_nxt;
         y <= y_nxt;
         pend <= |p_nxt;
      end
   assign {Y2, Y1, Y0} = y;
   assign VALID = (state == GRANT);
   assign PEND = pend;
endmodule
